// File: rtl/watchdog_pkg.sv
// watchdog_pkg
//   Shared constants and types for the watchdog eigen-analysis front-end.
//   COEF_HDR_BYTE   : frame header byte.
//   COEF_DATA_BYTES : data bytes per frame (a0 MSB..LSB, then a1 MSB..LSB).
//   coef_rx_state_t : receiver FSM states.
package watchdog_pkg;

  localparam logic [7:0]  COEF_HDR_BYTE   = 8'hA5;
  localparam int unsigned COEF_DATA_BYTES = 8;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    CKSUM,
    PEND
  } coef_rx_state_t;

endpackage

// File: rtl/pin_sync_edge.sv
// pin_sync_edge
//   Synchroniser chain for an asynchronous strobe and its data bus, followed
//   by a rising-edge detector on the synchronised strobe. Data travels through
//   a chain of the same depth so byte_val lines up with byte_evt.
//   Ports:
//     clk, rst_n      : clock, asynchronous active-low reset
//     async_strobe    : host strobe, asynchronous to clk
//     async_data[W]   : host data, asynchronous to clk
//     byte_evt        : one-cycle pulse on a synchronised strobe rise
//     byte_val[W]     : synchronised data, valid while byte_evt is high
module pin_sync_edge #(
  parameter int unsigned STAGES = 2,
  parameter int unsigned W      = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         async_strobe,
  input  logic [W-1:0] async_data,
  output logic         byte_evt,
  output logic [W-1:0] byte_val
);

  logic [STAGES-1:0] strobe_q;
  logic [W-1:0]      data_q [STAGES];
  logic              strobe_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_q    <= '0;
      strobe_prev <= 1'b0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      strobe_q    <= {strobe_q[STAGES-2:0], async_strobe};
      strobe_prev <= strobe_q[STAGES-1];
      data_q[0]   <= async_data;
      for (int unsigned i = 1; i < STAGES; i++) begin
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign byte_evt = strobe_q[STAGES-1] & ~strobe_prev;
  assign byte_val = data_q[STAGES-1];

endmodule

// File: rtl/coef_frame_rx.sv
// coef_frame_rx
//   Receives a byte-serial coefficient frame from the host pins, validates it
//   and launches the eigen core with the assembled a0/a1 coefficients.
//   Frame: 0xA5, a0[31:24..7:0], a1[31:24..7:0], [XOR checksum].
//   Build option: define COEF_RX_CKSUM_EN to include the checksum byte and
//   its check; without it a frame ends after the 8th data byte.
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     ena          : tile enable; low aborts any frame and forces IDLE
//     pin_data[8]  : host byte (asynchronous)
//     pin_strobe   : host byte strobe (asynchronous, rising edge = byte)
//     core_busy    : downstream busy, holds off start_calc
//     a0, a1       : signed coefficients, updated only with start_calc
//     start_calc   : one-cycle launch pulse
//     frame_err    : sticky error, cleared by the next valid header
//     rx_busy      : FSM not in IDLE
module coef_frame_rx
  import watchdog_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [7:0]         pin_data,
  input  logic               pin_strobe,
  input  logic               core_busy,
  output logic signed [31:0] a0,
  output logic signed [31:0] a1,
  output logic               start_calc,
  output logic               frame_err,
  output logic               rx_busy
);

  localparam int unsigned    TMO_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [2:0]     LAST_IDX = 3'(COEF_DATA_BYTES - 1);

  logic       byte_evt;
  logic [7:0] byte_val;

  pin_sync_edge #(
    .STAGES (SYNC_STAGES),
    .W      (8)
  ) u_sync (
    .clk          (clk),
    .rst_n        (rst_n),
    .async_strobe (pin_strobe),
    .async_data   (pin_data),
    .byte_evt     (byte_evt),
    .byte_val     (byte_val)
  );

  coef_rx_state_t     state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [7:0]         xacc_q, xacc_d;
  logic [63:0]        shadow_q, shadow_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic signed [31:0] a0_d, a1_d;
  logic               start_d;
  logic               err_d;
  logic               frame_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      xacc_q     <= '0;
      shadow_q   <= '0;
      tmo_q      <= '0;
      a0         <= '0;
      a1         <= '0;
      start_calc <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      xacc_q     <= xacc_d;
      shadow_q   <= shadow_d;
      tmo_q      <= tmo_d;
      a0         <= a0_d;
      a1         <= a1_d;
      start_calc <= start_d;
      frame_err  <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    xacc_d     = xacc_q;
    shadow_d   = shadow_q;
    tmo_d      = tmo_q;
    a0_d       = a0;
    a1_d       = a1;
    err_d      = frame_err;
    start_d    = 1'b0;
    frame_done = 1'b0;

    // Inter-byte timeout, shared by DATA and CKSUM.
    if (state_q == DATA || state_q == CKSUM) begin
      if (byte_evt) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_LAST) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (byte_evt && byte_val == COEF_HDR_BYTE) begin
          err_d   = 1'b0;
          cnt_d   = '0;
          xacc_d  = '0;
          tmo_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (byte_evt) begin
          shadow_d = {shadow_q[55:0], byte_val};
          xacc_d   = xacc_q ^ byte_val;
          cnt_d    = cnt_q + 3'd1;
          if (cnt_q == LAST_IDX) begin
`ifdef COEF_RX_CKSUM_EN
            state_d = CKSUM;
`else
            frame_done = 1'b1;
`endif
          end
        end
      end
`ifdef COEF_RX_CKSUM_EN
      CKSUM: begin
        if (byte_evt) begin
          if (byte_val == xacc_q) begin
            frame_done = 1'b1;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
`endif
      PEND: begin
        if (byte_evt) begin
          err_d = 1'b1;
        end
        frame_done = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // A completed frame launches in the same edge when the core is free, so
    // start_calc appears the cycle after the final byte event; otherwise it
    // parks in PEND. shadow_d already holds the last shifted byte.
    if (frame_done) begin
      if (core_busy) begin
        state_d = PEND;
      end else begin
        a0_d    = shadow_d[63:32];
        a1_d    = shadow_d[31:0];
        start_d = 1'b1;
        state_d = IDLE;
      end
    end

    if (!ena) begin
      state_d = IDLE;
      start_d = 1'b0;
      a0_d    = a0;
      a1_d    = a1;
      err_d   = frame_err;
    end
  end

  assign rx_busy = (state_q != IDLE);

endmodule
